pia_access_sequencer: RTL and testbench

Bus-side controller for the MC6820B PIA register port, side A. After reset it programs DDRA and CRA from parameters. It then shares the PIA's single register interface between two requesters, port 0 (CPU) and port 1 (host/debug), using round-robin arbitration. It owns CS, RS, rw and DI, and captures DO, so no requester drives the PIA directly.

---
 rtl/pia_pkg.sv | 19 +
 rtl/rr_arb2.sv | 28 ++
 rtl/pia_access_sequencer.sv | 153 +++++++++++++++
 tb/tb_pia_access_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pia_pkg.sv
// Shared constants and state encoding for the MC6820B side-A access sequencer.
package pia_pkg;

  localparam logic [2:0] CS_SEL      = 3'b011;
  localparam logic [2:0] CS_IDLE     = 3'b000;
  localparam logic [1:0] RS_DATA_DDR = 2'b00;
  localparam logic [1:0] RS_CTRL     = 2'b01;

  typedef enum logic [2:0] {
    StInitSel,
    StInitDdr,
    StInitCr,
    StIdle,
    StWrite,
    StRead,
    StCapture
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant pointer moves only when a grant is taken.
module rr_arb2 (
  input  logic       enable,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;

  always_comb begin
    gnt = req;
    // On a tie, favour the port that was not granted last.
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge enable) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (advance && (|gnt)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/pia_access_sequencer.sv
// Owns the PIA register port: programs DDRA/CRA after reset, then serialises
// register accesses from two requesters with round-robin arbitration.
module pia_access_sequencer
  import pia_pkg::*;
#(
  parameter logic [7:0] INIT_DDRA = 8'h00,
  parameter logic [7:0] INIT_CRA  = 8'h04
) (
  input  logic       enable,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] rs0,
  input  logic [1:0] rs1,
  input  logic       rd0,
  input  logic       rd1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       init_busy,
  output logic [2:0] pia_cs,
  output logic [1:0] pia_rs,
  output logic       pia_rw,
  output logic [7:0] pia_di,
  input  logic [7:0] pia_do
);

  state_e     state_q, state_d;
  logic       port_q, port_d;
  logic [2:0] cs_q, cs_d;
  logic [1:0] rs_q, rs_d;
  logic       rw_q, rw_d;
  logic [7:0] di_q, di_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       busy_q, busy_d;
  logic [1:0] gnt;
  logic       sel_rd;
  logic [1:0] sel_rs;
  logic [7:0] sel_wdata;

  rr_arb2 u_arb (
    .enable  (enable),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (state_q == StIdle),
    .gnt     (gnt)
  );

  assign sel_rd    = gnt[1] ? rd1    : rd0;
  assign sel_rs    = gnt[1] ? rs1    : rs0;
  assign sel_wdata = gnt[1] ? wdata1 : wdata0;

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    cs_d    = CS_IDLE;
    // RS=01 at idle keeps the PIA from clearing its flags on rw=1 cycles.
    rs_d    = RS_CTRL;
    rw_d    = 1'b1;
    di_d    = 8'h00;
    rdata_d = rdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    unique case (state_q)
      StInitSel: begin
        cs_d    = CS_SEL;
        rw_d    = 1'b0;
        di_d    = INIT_CRA & 8'hFB;
        state_d = StInitDdr;
      end
      StInitDdr: begin
        cs_d    = CS_SEL;
        rs_d    = RS_DATA_DDR;
        rw_d    = 1'b0;
        di_d    = INIT_DDRA;
        state_d = StInitCr;
      end
      StInitCr: begin
        cs_d    = CS_SEL;
        rw_d    = 1'b0;
        di_d    = INIT_CRA | 8'h04;
        state_d = StIdle;
      end
      StIdle: begin
        if (|gnt) begin
          port_d  = gnt[1];
          cs_d    = CS_SEL;
          rs_d    = sel_rs;
          rw_d    = sel_rd;
          di_d    = sel_rd ? 8'h00 : sel_wdata;
          state_d = sel_rd ? StRead : StWrite;
        end
      end
      StWrite: begin
        done0_d = ~port_q;
        done1_d = port_q;
        state_d = StIdle;
      end
      StRead: begin
        state_d = StCapture;
      end
      StCapture: begin
        // DO was registered by the PIA on the edge that closed the read cycle.
        rdata_d = pia_do;
        done0_d = ~port_q;
        done1_d = port_q;
        state_d = StIdle;
      end
      default: state_d = StInitSel;
    endcase
    busy_d = (state_d == StInitSel) || (state_d == StInitDdr) || (state_d == StInitCr);
  end

  always_ff @(posedge enable) begin
    if (reset) begin
      state_q <= StInitSel;
      port_q  <= 1'b0;
      cs_q    <= CS_IDLE;
      rs_q    <= RS_CTRL;
      rw_q    <= 1'b1;
      di_q    <= 8'h00;
      rdata_q <= 8'h00;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      cs_q    <= cs_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      di_q    <= di_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign pia_cs    = cs_q;
  assign pia_rs    = rs_q;
  assign pia_rw    = rw_q;
  assign pia_di    = di_q;
  assign rdata     = rdata_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign init_busy = busy_q;

endmodule

// File: tb/tb_pia_access_sequencer.sv
// Self-checking bench: PIA side-A register model plus a transaction-level reference model.
module tb_pia_access_sequencer;

  localparam logic [7:0] P_DDRA = 8'hF0;
  localparam logic [7:0] P_CRA  = 8'h04;
  localparam logic [7:0] PA_IN  = 8'h3C;

  logic       enable = 1'b0;
  logic       reset  = 1'b1;
  logic       r_req [2];
  logic [1:0] r_rs  [2];
  logic       r_rd  [2];
  logic [7:0] r_wd  [2];
  logic       done0, done1, init_busy, pia_rw;
  logic [7:0] rdata, pia_di, pia_do;
  logic [2:0] pia_cs;
  logic [1:0] pia_rs;

  int n_vec = 0;
  int n_err = 0;

  always #5 enable = ~enable;

  pia_access_sequencer #(
    .INIT_DDRA (P_DDRA),
    .INIT_CRA  (P_CRA)
  ) dut (
    .enable    (enable),
    .reset     (reset),
    .req0      (r_req[0]),
    .req1      (r_req[1]),
    .rs0       (r_rs[0]),
    .rs1       (r_rs[1]),
    .rd0       (r_rd[0]),
    .rd1       (r_rd[1]),
    .wdata0    (r_wd[0]),
    .wdata1    (r_wd[1]),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .init_busy (init_busy),
    .pia_cs    (pia_cs),
    .pia_rs    (pia_rs),
    .pia_rw    (pia_rw),
    .pia_di    (pia_di),
    .pia_do    (pia_do)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PIA side A: only what the sequencer touches.
  logic [7:0] p_ddra = 8'h00;
  logic [7:0] p_ora  = 8'h00;
  logic [5:0] p_cra  = 6'h00;
  logic [7:0] p_do   = 8'h00;
  assign pia_do = p_do;

  always @(posedge enable) begin
    if (pia_cs == 3'b011) begin
      if (!pia_rw) begin
        if (pia_rs == 2'b01) p_cra <= pia_di[5:0];
        else if (pia_rs == 2'b00) begin
          if (p_cra[2]) p_ora <= pia_di;
          else p_ddra <= pia_di;
        end
      end else begin
        if (pia_rs == 2'b01) p_do <= {2'b00, p_cra};
        else if (pia_rs == 2'b00) p_do <= p_cra[2] ? ((p_ora & p_ddra) | (PA_IN & ~p_ddra)) : p_ddra;
        else p_do <= 8'h00;
      end
    end
  end

  // Reference model: register contents plus service order and fixed latencies.
  logic [7:0] m_ddr = 8'h00, m_ora = 8'h00;
  logic [5:0] m_cra = 6'h00;
  logic [1:0] init_rs [3];
  logic [7:0] init_di [3];
  bit         armed = 0;
  int         init_cnt = 3, txn_left = 0, m_port = 0, m_last = 1, k;
  logic       m_rd = 1'b0;
  logic [7:0] m_val = 8'h00;
  logic [1:0] e_done = 2'b00;
  logic [7:0] e_rdata = 8'h00, e_di = 8'h00;
  logic [2:0] e_cs = 3'b000;
  logic [1:0] e_rs = 2'b01;
  logic       e_rw = 1'b1, e_busy = 1'b1;

  initial begin
    init_rs[0] = 2'b01; init_di[0] = P_CRA & 8'hFB;
    init_rs[1] = 2'b00; init_di[1] = P_DDRA;
    init_rs[2] = 2'b01; init_di[2] = P_CRA | 8'h04;
  end

  function automatic logic [7:0] m_read(input logic [1:0] rs);
    if (rs == 2'b01) return {2'b00, m_cra};
    if (rs == 2'b00) return m_cra[2] ? ((m_ora & m_ddr) | (PA_IN & ~m_ddr)) : m_ddr;
    return 8'h00;
  endfunction

  task automatic m_write(input logic [1:0] rs, input logic [7:0] d);
    if (rs == 2'b01) m_cra = d[5:0];
    else if (rs == 2'b00) begin
      if (m_cra[2]) m_ora = d;
      else m_ddr = d;
    end
  endtask

  always @(posedge enable) begin
    #1;
    e_done = 2'b00; e_cs = 3'b000; e_rs = 2'b01; e_rw = 1'b1; e_di = 8'h00;
    if (reset) begin
      armed = 1; init_cnt = 3; txn_left = 0; m_last = 1; e_rdata = 8'h00; e_busy = 1'b1;
    end else begin
      if (init_cnt > 0) begin
        k = 3 - init_cnt;
        e_cs = 3'b011; e_rw = 1'b0; e_rs = init_rs[k]; e_di = init_di[k];
        m_write(e_rs, e_di);
        init_cnt--;
      end else if (txn_left > 0) begin
        txn_left--;
        if (txn_left == 0) begin
          e_done[m_port] = 1'b1;
          if (m_rd) e_rdata = m_val;
        end
      end else if (r_req[0] || r_req[1]) begin
        if (r_req[0] && r_req[1]) m_port = 1 - m_last;
        else m_port = r_req[1] ? 1 : 0;
        m_last = m_port;
        m_rd = r_rd[m_port];
        e_cs = 3'b011; e_rs = r_rs[m_port]; e_rw = m_rd; e_di = m_rd ? 8'h00 : r_wd[m_port];
        if (m_rd) m_val = m_read(e_rs);
        else m_write(e_rs, e_di);
        txn_left = m_rd ? 2 : 1;
      end
      e_busy = (init_cnt > 0);
    end
    if (armed) begin
      check("done0", done0, e_done[0]);
      check("done1", done1, e_done[1]);
      check("rdata", rdata, e_rdata);
      check("init_busy", init_busy, e_busy);
      check("pia_cs", pia_cs, e_cs);
      check("pia_rs", pia_rs, e_rs);
      check("pia_rw", pia_rw, e_rw);
      check("pia_di", pia_di, e_di);
    end
  end

  task automatic tick();
    @(negedge enable);
  endtask

  task automatic do_req(input int p, input logic [1:0] rs, input logic rd, input logic [7:0] wd,
                        output int lat);
    r_req[p] = 1'b1; r_rs[p] = rs; r_rd[p] = rd; r_wd[p] = wd; lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (((p == 1) ? done1 : done0) === 1'b1) begin
        lat = i;
        break;
      end
    end
    r_req[p] = 1'b0;
  endtask

  int lat, cnt0, cnt1, d1_seen;
  int order [$];

  initial begin
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_rs[p] = 2'b01; r_rd[p] = 1'b1; r_wd[p] = 8'h00;
    end
    repeat (3) tick();
    check("reset cs", pia_cs, 3'b000);
    check("reset rs", pia_rs, 2'b01);
    check("reset busy", init_busy, 1'b1);
    reset = 1'b0;

    // Init: busy for two sampled cycles, low on the third.
    tick(); check("busy c1", init_busy, 1'b1);
    tick(); check("busy c2", init_busy, 1'b1);
    tick(); check("busy c3", init_busy, 1'b0);
    tick();
    check("init ddra", p_ddra, 8'hF0);
    check("init cra", p_cra, 6'h04);
    check("idle rs", pia_rs, 2'b01);
    check("idle rw", pia_rw, 1'b1);

    do_req(0, 2'b00, 1'b0, 8'hA5, lat);
    check("wr latency", lat, 2);
    check("pao", p_ora, 8'hA5);
    tick(); check("done0 single", done0, 1'b0);

    do_req(1, 2'b01, 1'b1, 8'h00, lat);
    check("rd latency", lat, 3);
    check("rd cra", rdata, 8'h04);

    // Both held: alternate grants, two transactions each.
    cnt0 = 0; cnt1 = 0;
    r_req[0] = 1'b1; r_rs[0] = 2'b00; r_rd[0] = 1'b0; r_wd[0] = 8'h11;
    r_req[1] = 1'b1; r_rs[1] = 2'b00; r_rd[1] = 1'b0; r_wd[1] = 8'h22;
    for (int i = 0; i < 40 && (cnt0 < 2 || cnt1 < 2); i++) begin
      tick();
      if (done0 === 1'b1) begin order.push_back(0); cnt0++; if (cnt0 == 2) r_req[0] = 1'b0; end
      if (done1 === 1'b1) begin order.push_back(1); cnt1++; if (cnt1 == 2) r_req[1] = 1'b0; end
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0;
    check("rr count", order.size(), 4);
    for (int i = 0; i < 4; i++) check("rr order", (i < order.size()) ? order[i] : 9, i % 2);

    // Select DDRA, overwrite it, then reset in the middle of a read.
    do_req(0, 2'b01, 1'b0, 8'h00, lat);
    do_req(0, 2'b00, 1'b0, 8'h0F, lat);
    check("ddra ovr", p_ddra, 8'h0F);
    r_req[1] = 1'b1; r_rs[1] = 2'b01; r_rd[1] = 1'b1;
    tick();
    check("rd cycle cs", pia_cs, 3'b011);
    check("rd cycle rw", pia_rw, 1'b1);
    reset = 1'b1; r_req[1] = 1'b0;
    tick();
    check("rst mid cs", pia_cs, 3'b000);
    check("rst mid done1", done1, 1'b0);
    reset = 1'b0;
    r_req[0] = 1'b1; r_rs[0] = 2'b00; r_rd[0] = 1'b0; r_wd[0] = 8'h5A;
    lat = 0; d1_seen = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (done1 === 1'b1) d1_seen++;
      if (done0 === 1'b1) begin lat = i; break; end
    end
    r_req[0] = 1'b0;
    check("init hold lat", lat, 5);
    check("no done1 abort", d1_seen, 0);
    check("ddra rerun", p_ddra, 8'hF0);
    check("pao after init", p_ora, 8'h5A);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(399) == 0) reset = 1'b1;
      for (int p = 0; p < 2; p++) begin
        if (reset) r_req[p] = 1'b0;
        else if (r_req[p]) begin
          if (((p == 1) ? done1 : done0) === 1'b1) begin
            if ($urandom_range(9) < 7) r_req[p] = 1'b0;
            else begin
              r_rs[p] = 2'($urandom_range(1)); r_rd[p] = 1'($urandom_range(1));
              r_wd[p] = 8'($urandom);
            end
          end else if ($urandom_range(19) == 0) r_req[p] = 1'b0;
        end else if ($urandom_range(9) < 3) begin
          r_req[p] = 1'b1; r_rs[p] = 2'($urandom_range(1)); r_rd[p] = 1'($urandom_range(1));
          r_wd[p] = 8'($urandom);
        end
      end
    end
    r_req[0] = 1'b0; r_req[1] = 1'b0; reset = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
